// File: rtl/sync_debounce.sv
// Multi-channel input conditioner: synchroniser chain, debounce filter,
// registered rise/fall pulses and a sticky per-channel event flag.
module sync_debounce #(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      STAGES    = 2,
    parameter int unsigned      DB_CYCLES = 4,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] evt_pend
);

    localparam int unsigned      CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]             sync_d;

    // Plain shift chain; no logic between stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[STAGES-1];
    // Debounce judges the level sync_out takes at this edge, so acceptance
    // lands STAGES+DB_CYCLES-1 edges after first capture.
    assign sync_d   = sync_q[STAGES-2];

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic             stable_q;
        logic             rise_q;
        logic             fall_q;
        logic             evt_q;
        logic             accept_c;

        assign accept_c = (sync_d[i] != stable_q) && (cnt_q == CNT_MAX);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q    <= '0;
                stable_q <= RST_VAL[i];
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                evt_q    <= 1'b0;
            end else begin
                rise_q <= accept_c &  sync_d[i];
                fall_q <= accept_c & ~sync_d[i];
                // A pulse arriving with a clear still sets the flag
                evt_q  <= (evt_q & ~evt_clr[i]) | rise_q | fall_q;
                if (sync_d[i] == stable_q) begin
                    cnt_q <= '0;
                end else if (accept_c) begin
                    stable_q <= sync_d[i];
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign stable_out[i] = stable_q;
        assign rise[i]       = rise_q;
        assign fall[i]       = fall_q;
        assign evt_pend[i]   = evt_q;
    end

endmodule

// File: tb/tb_sync_debounce.sv
// Randomised + directed scoreboard bench for sync_debounce against a
// window-based reference model of synchronisation and debouncing.
module tb_sync_debounce;

    localparam int unsigned W      = 4;
    localparam int unsigned STAGES = 2;
    localparam int unsigned DB     = 4;
    localparam logic [W-1:0] RV    = 4'b0101;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] async_in;
    logic [W-1:0] evt_clr;
    logic [W-1:0] sync_out;
    logic [W-1:0] stable_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] evt_pend;

    typedef struct packed {
        logic [W-1:0] sync;
        logic [W-1:0] stable;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] evt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_rise = 0;
    int   n_fall = 0;

    // Reference model state
    logic [W-1:0] m_samp[$];
    logic [W-1:0] m_lvl[$];
    logic [W-1:0] m_stable;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    logic [W-1:0] m_evt;
    logic         prev_rst = 1'b1;

    sync_debounce #(
        .WIDTH    (W),
        .STAGES   (STAGES),
        .DB_CYCLES(DB),
        .RST_VAL  (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .async_in  (async_in),
        .evt_clr   (evt_clr),
        .sync_out  (sync_out),
        .stable_out(stable_out),
        .rise      (rise),
        .fall      (fall),
        .evt_pend  (evt_pend)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Predict outputs after the coming posedge. A channel accepts a new level
    // once the last DB synchronised levels since reset all differ from stable.
    task automatic model_edge(input logic r, input logic [W-1:0] a, input logic [W-1:0] c);
        exp_t         e;
        logic [W-1:0] lvl;
        logic         flip;
        if (r) begin
            m_samp = {};
            repeat (STAGES) m_samp.push_back(RV);
            m_lvl    = {};
            m_stable = RV;
            m_rise   = '0;
            m_fall   = '0;
            m_evt    = '0;
        end else begin
            m_evt = (m_evt & ~c) | m_rise | m_fall;
            m_samp.push_back(a);
            void'(m_samp.pop_front());
            lvl = m_samp[0];
            m_lvl.push_back(lvl);
            if (m_lvl.size() > DB) void'(m_lvl.pop_front());
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                flip = (m_lvl.size() == DB);
                for (int k = 0; k < m_lvl.size(); k++)
                    if (m_lvl[k][i] == m_stable[i]) flip = 1'b0;
                if (flip) begin
                    m_stable[i] = lvl[i];
                    if (lvl[i]) m_rise[i] = 1'b1;
                    else        m_fall[i] = 1'b1;
                end
            end
        end
        e.sync   = m_samp[0];
        e.stable = m_stable;
        e.rise   = m_rise;
        e.fall   = m_fall;
        e.evt    = m_evt;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic [W-1:0] a, input logic [W-1:0] c);
        @(negedge clk);
        rst      = r;
        async_in = a;
        evt_clr  = c;
        if (r && !prev_rst) begin
            #1;
            cmp("async_rst_sync",   sync_out,   RV);
            cmp("async_rst_stable", stable_out, RV);
            cmp("async_rst_rise",   rise,       '0);
            cmp("async_rst_fall",   fall,       '0);
            cmp("async_rst_evt",    evt_pend,   '0);
        end
        prev_rst = r;
        model_edge(r, a, c);
    endtask

    // Monitor: every cycle presents an output word
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cmp("sync_out",   sync_out,   e.sync);
                cmp("stable_out", stable_out, e.stable);
                cmp("rise",       rise,       e.rise);
                cmp("fall",       fall,       e.fall);
                cmp("evt_pend",   evt_pend,   e.evt);
                n_rise += $countones(rise);
                n_fall += $countones(fall);
            end
        end
    end

    initial begin
        int           hold [W];
        logic [W-1:0] lvl;
        logic [W-1:0] clr;
        rst      = 1'b1;
        async_in = RV;
        evt_clr  = '0;

        // Reset hold, then quiet release with inputs at the reset level
        repeat (3)  step(1'b1, RV, '0);
        repeat (20) step(1'b0, RV, '0);

        // Bring all low, clear flags, then latency of a single rise on ch0
        repeat (10) step(1'b0, 4'b0000, '0);
        step(1'b0, 4'b0000, 4'hF);
        repeat (8)  step(1'b0, 4'b0001, '0);

        // ch1: 3-cycle glitch is rejected, 4-cycle pulse is accepted
        repeat (3)  step(1'b0, 4'b0011, '0);
        repeat (6)  step(1'b0, 4'b0001, '0);
        repeat (4)  step(1'b0, 4'b0011, '0);
        repeat (8)  step(1'b0, 4'b0001, '0);

        // ch2: clear collides with rise (evt_clr sampled at E6), later isolated clear
        for (int k = 0; k < 10; k++)
            step(1'b0, 4'b0101, (k == 5) ? 4'b0100 : 4'b0000);
        step(1'b0, 4'b0101, 4'b0100);
        repeat (3)  step(1'b0, 4'b0101, '0);

        // Opposite edges on ch0 and ch3 in the same cycle
        repeat (8)  step(1'b0, 4'b1000, 4'hF);
        repeat (8)  step(1'b0, 4'b0001, '0);

        // Reset at count 2 on ch1, then full debounce after release
        repeat (3)  step(1'b0, 4'b0011, '0);
        step(1'b1, 4'b0011, '0);
        repeat (10) step(1'b0, 4'b0011, '0);

        // Randomised hold lengths per channel, random clears, rare resets
        lvl = async_in;
        for (int i = 0; i < W; i++) hold[i] = int'($urandom_range(1, 7));
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < W; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    lvl[i]  = ~lvl[i];
                    hold[i] = int'($urandom_range(1, 7));
                end
            end
            clr = '0;
            for (int i = 0; i < W; i++) clr[i] = ($urandom_range(0, 7) == 0);
            step(($urandom_range(0, 299) == 0), lvl, clr);
        end
        step(1'b0, lvl, '0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
        end
        checks++;
        if (n_rise == 0 || n_fall == 0) begin
            errors++;
            $display("FAIL activity: rise pulses %0d fall pulses %0d, required both > 0", n_rise, n_fall);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
